// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding,
// the SPI mode the slave implements and the default word length.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Mode 0: sclk idles low, data sampled on the rising edge
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_slave_if.sv
// Bundles the serial pins and the parallel TX/RX side of the SPI slave.
interface spi_slave_if #(
    parameter int DATA_WIDTH = spi_pkg::DEFAULT_DATA_WIDTH
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_sync.sv
// Single-bit synchronizer with rising/falling edge detection. The edge
// flop compares the last synchronizer stage against one more delayed copy.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus the delayed copy used for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  q_o & ~prev_q;
    assign fall_o = ~q_o &  prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, fully synchronous to clk. sclk/cs_n/mosi are
// oversampled; a one-entry TX buffer feeds the transmit shift register
// at chip-select fall and at every word boundary.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic sample_edge, shift_edge;
    logic capture, load;
    logic unused_sync;

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic                  reload_q, reload_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(bus.sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(bus.cs_n),
        .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(bus.mosi),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    // Only edges of sclk/cs_n and the level of mosi are needed
    assign unused_sync = &{1'b0, sclk_s, cs_s, mosi_rise, mosi_fall};

    assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
    assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;
    assign capture     = bus.tx_valid & ~buf_full_q;

    // Next-state logic: FSM, bit counter, shift registers and TX buffer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        reload_d   = reload_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d  = ACTIVE;
                    load     = 1'b1;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    rx_sh_d  = '0;
                end
            end
            ACTIVE: begin
                // Word completion is evaluated before a simultaneous deselect
                if (sample_edge) begin
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        reload_d   = 1'b1;
                        rx_data_d  = rx_sh_d;
                        rx_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (cs_rise) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    rx_sh_d  = '0;
                end else if (shift_edge) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load always sees the buffer as it was at the start of the cycle
        if (load) begin
            tx_sh_d    = buf_full_q ? buf_q : '0;
            underrun_d = ~buf_full_q;
        end
        if (capture) begin
            buf_d      = bus.tx_data;
            buf_full_d = 1'b1;
        end else if (load) begin
            buf_full_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            reload_q   <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            reload_q   <= reload_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.busy        = (state_q == ACTIVE);
    assign bus.miso_oe     = (state_q == ACTIVE);
    assign bus.miso        = (state_q == ACTIVE) & tx_sh_q[DATA_WIDTH-1];
    assign bus.tx_ready    = ~buf_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: mode-0 transfers driven with a slow sclk
// (8 clk cycles per phase), outputs compared against hand-computed values.
module tb_spi_slave;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   rxv_cnt = 0;
    int   und_cnt = 0;
    int   rdy_rise = 0;
    logic rdy_prev = 1'b0;

    spi_slave_if #(.DATA_WIDTH(8)) bus ();

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Event counters sampled away from the active edge
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rxv_cnt++;
        if (bus.tx_underrun === 1'b1) und_cnt++;
        if (bus.tx_ready === 1'b1 && rdy_prev !== 1'b1) rdy_rise++;
        rdy_prev = bus.tx_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int k;
        k = 0;
        while (bus.tx_ready !== 1'b1 && k < 200) begin
            wait_clk(1);
            k++;
        end
        check("push_ready", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        wait_clk(1);
        bus.tx_valid = 1'b0;
    endtask

    // n bits MSB first; sclk is left high after the last rising edge
    task automatic send_bits(input logic [7:0] w, input int n, input bit end_cs,
                             output logic [7:0] m);
        m = '0;
        for (int i = 0; i < n; i++) begin
            bus.mosi = w[7-i];
            wait_clk(HALF);
            m[7-i] = bus.miso;
            bus.sclk = 1'b1;
            if (end_cs && i == n - 1) bus.cs_n = 1'b1;
            wait_clk(HALF);
            if (i != n - 1) bus.sclk = 1'b0;
        end
    endtask

    task automatic end_xfer();
        bus.sclk = 1'b0;
        wait_clk(HALF);
        bus.cs_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        logic [7:0] m1, m2;
        int rb, ub, yb;

        rst = 1'b0;
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0;
        wait_clk(4);
        check("rst_miso", bus.miso, 0);
        check("rst_miso_oe", bus.miso_oe, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_underrun", bus.tx_underrun, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        rst = 1'b1;
        wait_clk(3);

        // Single word: TX 0xA5, RX 0x3C
        push_tx(8'hA5);
        check("t1_ready_low", bus.tx_ready, 0);
        rb = rxv_cnt;
        bus.cs_n = 1'b0;
        wait_clk(6);
        check("t1_busy", bus.busy, 1);
        check("t1_oe", bus.miso_oe, 1);
        check("t1_msb", bus.miso, 1);
        send_bits(8'h3C, 8, 1'b0, m1);
        check("t1_rx", bus.rx_data, 8'h3C);
        check("t1_rxv", rxv_cnt - rb, 1);
        check("t1_miso", m1, 8'hA5);
        end_xfer();
        check("t1_idle", bus.busy, 0);
        check("t1_oe_off", bus.miso_oe, 0);

        // Back-to-back words, second TX word loaded during the first
        push_tx(8'h12);
        rb = rxv_cnt; yb = rdy_rise;
        bus.cs_n = 1'b0;
        wait_clk(6);
        push_tx(8'h34);
        send_bits(8'hF0, 8, 1'b0, m1);
        check("t2_rx1", bus.rx_data, 8'hF0);
        bus.sclk = 1'b0;
        wait_clk(HALF);
        send_bits(8'h0F, 8, 1'b0, m2);
        check("t2_rx2", bus.rx_data, 8'h0F);
        check("t2_rxv", rxv_cnt - rb, 2);
        check("t2_miso1", m1, 8'h12);
        check("t2_miso2", m2, 8'h34);
        check("t2_ready_rises", rdy_rise - yb, 2);
        end_xfer();

        // Empty TX buffer at select
        rb = rxv_cnt; ub = und_cnt;
        bus.cs_n = 1'b0;
        wait_clk(6);
        send_bits(8'h5A, 8, 1'b0, m1);
        check("t3_underrun", und_cnt - ub, 1);
        check("t3_miso", m1, 8'h00);
        check("t3_rx", bus.rx_data, 8'h5A);
        check("t3_rxv", rxv_cnt - rb, 1);
        end_xfer();

        // Abort after 5 bits; buffered word must survive
        push_tx(8'hC3);
        rb = rxv_cnt;
        bus.cs_n = 1'b0;
        wait_clk(6);
        push_tx(8'h96);
        send_bits(8'hFF, 5, 1'b0, m1);
        end_xfer();
        check("t4_rxv", rxv_cnt - rb, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_cnt", dut.cnt_q, 0);
        check("t4_buf_kept", bus.tx_ready, 0);
        check("t4_rx_kept", bus.rx_data, 8'h5A);
        bus.cs_n = 1'b0;
        wait_clk(6);
        send_bits(8'h69, 8, 1'b0, m1);
        check("t4_rx_next", bus.rx_data, 8'h69);
        check("t4_miso_next", m1, 8'h96);
        check("t4_rxv_next", rxv_cnt - rb, 1);
        end_xfer();

        // Asynchronous reset after 3 bits
        push_tx(8'h5A);
        bus.cs_n = 1'b0;
        wait_clk(6);
        push_tx(8'h11);
        rb = rxv_cnt;
        send_bits(8'hAA, 3, 1'b0, m1);
        rst = 1'b0;
        #2;
        check("t5_busy", bus.busy, 0);
        check("t5_oe", bus.miso_oe, 0);
        check("t5_miso", bus.miso, 0);
        check("t5_ready", bus.tx_ready, 1);
        check("t5_rx_data", bus.rx_data, 0);
        check("t5_rxv", bus.rx_valid, 0);
        check("t5_cnt", dut.cnt_q, 0);
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(3);
        check("t5_no_strobe", rxv_cnt - rb, 0);
        push_tx(8'hE7);
        bus.cs_n = 1'b0;
        wait_clk(6);
        send_bits(8'h81, 8, 1'b0, m1);
        check("t5_rx_next", bus.rx_data, 8'h81);
        check("t5_miso_next", m1, 8'hE7);
        end_xfer();

        // Last sclk rise coincides with cs_n rise
        rb = rxv_cnt; ub = und_cnt;
        bus.cs_n = 1'b0;
        wait_clk(6);
        send_bits(8'hC6, 8, 1'b1, m1);
        check("t6_rx", bus.rx_data, 8'hC6);
        check("t6_rxv", rxv_cnt - rb, 1);
        check("t6_idle", bus.busy, 0);
        bus.sclk = 1'b0;
        wait_clk(HALF);
        check("t6_underrun", und_cnt - ub, 1);
        check("t6_miso", m1, 8'h00);
        check("t6_state", dut.state_q, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word length in bits (legal range 4..32).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for sclk, cs_n and mosi (legal range 2..3).
REQ-003 clk  input  1  system clock; the block SHALL use one clock only, and all logic SHALL be on the posedge of clk.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 mosi  input  1  serial data from the master.
REQ-008 miso  output  1  serial data to the master, MSB first.
REQ-009 miso_oe  output  1  output enable for the pad tri-state; high only while selected.
REQ-010 tx_data  input  DATA_WIDTH  next word to transmit.
REQ-011 tx_valid / tx_ready  input / output  1  valid/ready load handshake into a one-entry TX buffer.
REQ-012 rx_data  output  DATA_WIDTH  last complete received word.
REQ-013 rx_valid  output  1  one-cycle strobe when rx_data updates.
REQ-014 tx_underrun  output  1  one-cycle strobe when a word load finds the TX buffer empty.
REQ-015 busy  output  1  high while in the ACTIVE state.

Function
REQ-016 SPI mode 0 SHALL apply (CPOL=0, CPHA=0): mosi is sampled on sclk rising, miso changes on sclk falling, and data is MSB first.
REQ-017 sclk, cs_n and mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last synced stage to one further flop.
REQ-018 FSM states SHALL be IDLE and ACTIVE:
  - IDLE->ACTIVE on a synced cs_n falling edge.
  - ACTIVE->IDLE on a synced cs_n rising edge.
REQ-019 On IDLE->ACTIVE, the TX shift register SHALL load from the TX buffer, or all zeros if the buffer is empty (tx_underrun pulses). The bit counter SHALL clear, and miso SHALL present the MSB in the same cycle miso_oe rises.
REQ-020 In ACTIVE, each synced sclk rising edge SHALL shift synced mosi into the RX shift register LSB and increment the bit counter.
REQ-021 On the rising edge that makes the count equal DATA_WIDTH:
  - rx_data SHALL take the full word and rx_valid SHALL pulse on the next clk cycle.
  - The counter SHALL wrap to 0.
  - A reload flag SHALL set.
REQ-022 On a synced sclk falling edge in ACTIVE:
  - If the reload flag is set, the TX shift register SHALL reload per REQ-019 and the flag SHALL clear.
  - Otherwise the TX shift register SHALL shift left by one.
  - miso SHALL always equal the TX shift register MSB.
REQ-023 tx_ready SHALL be high when the TX buffer is empty. The buffer SHALL capture tx_data when tx_valid and tx_ready are both high, and SHALL empty on load into the shift register.
REQ-024 If a capture and a load occur in the same cycle, the load SHALL take the old buffer content and the buffer SHALL hold the new word.
REQ-025 A cs_n rise mid-word SHALL abort the transfer:
  - The partial RX word SHALL be discarded, with no rx_valid.
  - The counter and reload flag SHALL clear.
  - The TX buffer contents SHALL be retained.
REQ-026 If the final rising sclk edge and the cs_n rise are detected in the same cycle, word completion (REQ-021) SHALL take effect first, then the FSM SHALL go to IDLE.
REQ-027 There SHALL be no RX backpressure; a new rx_valid SHALL overwrite rx_data.
REQ-028 sclk edges while in IDLE SHALL be ignored.
REQ-029 Each sclk high and low phase SHALL be at least SYNC_STAGES+2 clk cycles. This is met by a local master using clk_div with CLK_DIVIDE >= 8.
REQ-030 miso SHALL update within SYNC_STAGES+2 clk cycles of a sclk falling edge.

Reset
REQ-031 While rst is low:
  - The FSM SHALL be in IDLE.
  - miso, miso_oe, rx_valid, tx_underrun and busy SHALL be 0.
  - rx_data SHALL be all zeros.
  - tx_ready SHALL be 1, and the TX buffer SHALL be empty.
  - The counter, the shift registers and all synchronizer flops SHALL be 0, except the cs_n flops, which SHALL be 1.
REQ-032 Reset assertion mid-transfer SHALL take effect immediately (asynchronously) with no completion strobe.

Structure
REQ-033 Package spi_pkg SHALL hold the state enum (IDLE, ACTIVE), the SPI mode constants, and the default DATA_WIDTH.
REQ-034 Sub-module spi_sync SHALL implement the synchronizer plus rise/fall edge detect for a single bit, instantiated three times.

Verification
REQ-035 Reset, then cs_n low with tx_data=0xA5 preloaded, then 8 sclk periods with mosi carrying 0x3C -> rx_data=0x3C with one rx_valid pulse; miso bits read 1,0,1,0,0,1,0,1.
REQ-036 Two back-to-back words with cs_n held low, TX 0x12 then 0x34 loaded during word 1, RX 0xF0 then 0x0F -> two rx_valid pulses; miso carries 0x12 then 0x34; tx_ready rises twice.
REQ-037 Empty TX buffer at cs_n fall -> tx_underrun pulses once; miso is 0 for all 8 bits; RX still completes.
REQ-038 cs_n rise after 5 sclk rising edges -> no rx_valid, busy falls, counter returns to 0; the next full transfer receives its correct value.
REQ-039 rst pulsed low after 3 bits -> all outputs reach their reset values asynchronously; the next transfer is correct.
REQ-040 Final sclk rise and cs_n rise aligned within one clk cycle -> rx_valid asserted once with the correct word, FSM ends in IDLE.
